cache_line_fill: RTL and testbench

CACHE_LINE_FILL -- requirements
Module: cache_line_fill

---
 rtl/cache_pkg.sv | 27 ++
 rtl/fill_watchdog.sv | 39 +++
 rtl/cache_line_fill.sv | 147 ++++++++++++++
 tb/tb_cache_line_fill.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// ============================================================================
// cache_pkg
// Shared types and constants for the cache line-fill engine and the cache
// control FSM that drives it.
// Revision: 1.0
// ============================================================================
`default_nettype none

package cache_pkg;

   // Line-fill engine states
   typedef enum logic [1:0] {
      FILL_IDLE   = 2'd0,
      FILL_FETCH  = 2'd1,
      FILL_COMMIT = 2'd2
   } fill_state_t;

   // Default line geometry
   localparam int CACHE_WORDS_PER_LINE = 8;
   localparam int CACHE_DATA_W         = 32;

   // Number of byte-offset bits covered by one cache line
   localparam int CACHE_LINE_OFF_W = $clog2(CACHE_WORDS_PER_LINE * CACHE_DATA_W / 8);

endpackage

`default_nettype wire

// File: rtl/fill_watchdog.sv
// ============================================================================
// fill_watchdog
// Counts consecutive stalled FETCH cycles (active with no memory response).
// Raises expire on the TIMEOUT_CYC-th consecutive stalled cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fill_watchdog #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic active,
   input  logic valid,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] stall_cnt;

   // Fires on the last permitted stall cycle so the FSM leaves FETCH at that edge
   assign expire = active && !valid && (stall_cnt == CW'(TIMEOUT_CYC - 1));

   // Stall counter: clears on acceptance, on leaving FETCH and on expiry
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         stall_cnt <= '0;
      end else if (!active || valid || expire) begin
         stall_cnt <= '0;
      end else begin
         stall_cnt <= stall_cnt + CW'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/cache_line_fill.sv
// ============================================================================
// cache_line_fill
// Fetches a whole cache line from main memory one word at a time, writes each
// word into the data array as it arrives, then strobes the tag/valid write.
// Optional stall timeout: define CACHE_FILL_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module cache_line_fill
   import cache_pkg::*;
#(
   parameter int WORDS_PER_LINE = CACHE_WORDS_PER_LINE,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = CACHE_DATA_W,
   parameter int TIMEOUT_CYC    = 64
) (
   input  logic                              CLK,
   input  logic                              RST_N,
   input  logic                              fill_req,
   input  logic [ADDR_W-1:0]                 miss_addr,
   output logic                              mem_rd_en,
   output logic [ADDR_W-1:0]                 mem_addr,
   input  logic                              mem_valid,
   input  logic [DATA_W-1:0]                 mem_rdata,
   output logic                              cache_we,
   output logic [$clog2(WORDS_PER_LINE)-1:0] cache_widx,
   output logic [DATA_W-1:0]                 cache_wdata,
   output logic                              cache_tag_we,
   output logic                              fill_busy,
   output logic                              fill_done,
   output logic                              fill_err
);

   localparam int IDX_W   = $clog2(WORDS_PER_LINE);
   localparam int BYTE_SH = $clog2(DATA_W / 8);
   localparam int OFF_W   = IDX_W + BYTE_SH;
   localparam logic [ADDR_W-1:0] BASE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

   fill_state_t       state;
   fill_state_t       state_nxt;
   logic [IDX_W-1:0]  cnt;
   logic [ADDR_W-1:0] base;
   logic              accept;
   logic              last_word;
   logic              timeout;

   assign accept     = (state == FILL_FETCH) && mem_valid;
   assign last_word  = (cnt == IDX_W'(WORDS_PER_LINE - 1));
   assign cache_widx = cnt;

`ifdef CACHE_FILL_TIMEOUT_EN
   logic err_q;

   fill_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_fill_watchdog (
      .CLK    (CLK),
      .RST_N  (RST_N),
      .active (state == FILL_FETCH),
      .valid  (mem_valid),
      .expire (timeout)
   );

   // One-cycle abort pulse, registered so it appears while back in IDLE
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         err_q <= 1'b0;
      end else begin
         err_q <= timeout;
      end
   end

   assign fill_err = err_q;
`else
   logic [31:0] unused_timeout_cyc;

   assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
   assign timeout            = 1'b0;
   assign fill_err           = 1'b0;
`endif

   // State, line base and word counter registers
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= FILL_IDLE;
         cnt   <= '0;
         base  <= '0;
      end else begin
         state <= state_nxt;
         if (state == FILL_IDLE && fill_req) begin
            base <= miss_addr & BASE_MASK;
            cnt  <= '0;
         end else if (accept) begin
            // Power-of-two line: increment wraps to 0 after the last word
            cnt <= cnt + IDX_W'(1);
         end else if (timeout) begin
            cnt <= '0;
         end
      end
   end

   // Next-state decode and state-driven outputs
   always_comb begin
      state_nxt    = state;
      mem_rd_en    = 1'b0;
      mem_addr     = '0;
      cache_we     = 1'b0;
      cache_wdata  = '0;
      cache_tag_we = 1'b0;
      fill_busy    = 1'b0;
      fill_done    = 1'b0;
      case (state)
         FILL_IDLE: begin
            if (fill_req) begin
               state_nxt = FILL_FETCH;
            end
         end
         FILL_FETCH: begin
            fill_busy = 1'b1;
            mem_rd_en = 1'b1;
            mem_addr  = base + (ADDR_W'(cnt) << BYTE_SH);
            if (mem_valid) begin
               cache_we    = 1'b1;
               cache_wdata = mem_rdata;
               if (last_word) begin
                  state_nxt = FILL_COMMIT;
               end
            end else if (timeout) begin
               state_nxt = FILL_IDLE;
            end
         end
         FILL_COMMIT: begin
            fill_busy    = 1'b1;
            cache_tag_we = 1'b1;
            fill_done    = 1'b1;
            state_nxt    = FILL_IDLE;
         end
         default: begin
            state_nxt = FILL_IDLE;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_cache_line_fill.sv
// ============================================================================
// tb_cache_line_fill
// Directed bench for cache_line_fill with a write scoreboard: each fill pushes
// the eight expected (index, address, data) writes; every cache_we pops one.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_cache_line_fill;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int WPL = 8;
   localparam int TO  = 64;

   logic          CLK = 1'b0;
   logic          RST_N = 1'b0;
   logic          fill_req = 1'b0;
   logic [AW-1:0] miss_addr = '0;
   logic          mem_valid = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          mem_rd_en;
   logic [AW-1:0] mem_addr;
   logic          cache_we;
   logic [2:0]    cache_widx;
   logic [DW-1:0] cache_wdata;
   logic          cache_tag_we;
   logic          fill_busy;
   logic          fill_done;
   logic          fill_err;

   cache_line_fill #(
      .WORDS_PER_LINE (WPL),
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYC    (TO)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .fill_req     (fill_req),
      .miss_addr    (miss_addr),
      .mem_rd_en    (mem_rd_en),
      .mem_addr     (mem_addr),
      .mem_valid    (mem_valid),
      .mem_rdata    (mem_rdata),
      .cache_we     (cache_we),
      .cache_widx   (cache_widx),
      .cache_wdata  (cache_wdata),
      .cache_tag_we (cache_tag_we),
      .fill_busy    (fill_busy),
      .fill_done    (fill_done),
      .fill_err     (fill_err)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [2:0]  idx;
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t         sb[$];
   int          errors = 0;
   int          checks = 0;
   int          we_cnt = 0;
   int          tag_cnt = 0;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          mode = 0;
   int          cyc = 0;
   logic        prev_stall = 1'b0;
   logic [31:0] prev_addr = '0;
   logic        last_done = 1'b0;
   logic        last_busy = 1'b0;
   logic        last_err = 1'b0;

   function automatic logic [31:0] data_of(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_line(input logic [31:0] base);
      for (int i = 0; i < WPL; i++) begin
         sb.push_back('{idx: 3'(i), addr: base + 32'(i * 4), data: data_of(base + 32'(i * 4))});
      end
   endtask

   // One clock cycle: drive memory, sample at the falling edge, resume after the rising edge
   task automatic tick();
      wr_t e;
      cyc++;
      case (mode)
         0:       mem_valid = 1'b1;
         1:       mem_valid = (cyc % 3 == 0);
         default: mem_valid = 1'b0;
      endcase
      mem_rdata = data_of(mem_addr);
      @(negedge CLK);
      if (prev_stall && mem_rd_en) chk("addr_stable", mem_addr, prev_addr);
      prev_stall = mem_rd_en && !mem_valid;
      prev_addr  = mem_addr;
      if (cache_we) begin
         we_cnt++;
         if (sb.size() == 0) begin
            chk("sb_nonempty", 32'(sb.size()), 32'd1);
         end else begin
            e = sb.pop_front();
            chk("widx", 32'(cache_widx), 32'(e.idx));
            chk("mem_addr", mem_addr, e.addr);
            chk("wdata", cache_wdata, e.data);
         end
      end
      if (cache_tag_we) tag_cnt++;
      if (fill_done) done_cnt++;
      if (fill_err) err_cnt++;
      last_done = fill_done;
      last_busy = fill_busy;
      last_err  = fill_err;
      @(posedge CLK);
      #1;
   endtask

   task automatic start_fill(input logic [31:0] addr, input logic [31:0] base);
      miss_addr = addr;
      fill_req  = 1'b1;
      push_line(base);
      tick();
      fill_req = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound);
      for (int i = 0; i < bound; i++) begin
         tick();
         if (last_done) break;
      end
      chk(tag, 32'(last_done), 32'd1);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_rd_en"}, 32'(mem_rd_en), 32'd0);
      chk({tag, "_addr"}, mem_addr, 32'd0);
      chk({tag, "_we"}, 32'(cache_we), 32'd0);
      chk({tag, "_widx"}, 32'(cache_widx), 32'd0);
      chk({tag, "_wdata"}, cache_wdata, 32'd0);
      chk({tag, "_tag_we"}, 32'(cache_tag_we), 32'd0);
      chk({tag, "_busy"}, 32'(fill_busy), 32'd0);
      chk({tag, "_done"}, 32'(fill_done), 32'd0);
      chk({tag, "_err"}, 32'(fill_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=stuck expected=finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int w0;
      int t0;
      int d0;
      int e0;
      int err_at;

      // Reset state, with mem_valid high to show it is ignored
      mem_valid = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      @(posedge CLK);
      #1;
      check_all_zero("reset");
      RST_N = 1'b1;

      // Zero-wait fill: done exactly at cycle 9, busy in cycles 1..9
      mode = 0;
      t0 = tag_cnt;
      w0 = we_cnt;
      start_fill(32'h0000_1034, 32'h0000_1020);
      chk("c0_busy", 32'(last_busy), 32'd0);
      for (int c = 1; c <= 10; c++) begin
         tick();
         chk($sformatf("c%0d_busy", c), 32'(last_busy), 32'(c <= 9));
         chk($sformatf("c%0d_done", c), 32'(last_done), 32'(c == 9));
      end
      chk("zw_we_count", 32'(we_cnt - w0), 32'd8);
      chk("zw_tag_count", 32'(tag_cnt - t0), 32'd1);
      chk("zw_sb_drained", 32'(sb.size()), 32'd0);

      // Sparse memory: valid every third cycle, address held between acceptances
      mode = 1;
      t0 = tag_cnt;
      w0 = we_cnt;
      start_fill(32'h0000_401C, 32'h0000_4000);
      wait_done("sparse_done", 60);
      tick();
      chk("sparse_we_count", 32'(we_cnt - w0), 32'd8);
      chk("sparse_tag_count", 32'(tag_cnt - t0), 32'd1);
      chk("sparse_sb_drained", 32'(sb.size()), 32'd0);

      // Second request mid-FETCH is ignored; the following fill uses it
      mode = 0;
      start_fill(32'h0000_1034, 32'h0000_1020);
      tick();
      tick();
      miss_addr = 32'h0000_2000;
      fill_req  = 1'b1;
      tick();
      fill_req = 1'b0;
      wait_done("ignore_done", 20);
      tick();
      chk("ignore_sb_drained", 32'(sb.size()), 32'd0);
      chk("ignore_idle", 32'(last_busy), 32'd0);
      start_fill(32'h0000_2000, 32'h0000_2000);
      wait_done("next_done", 20);
      tick();
      chk("next_sb_drained", 32'(sb.size()), 32'd0);

      // Asynchronous reset at word 4 of a fill
      mode = 0;
      w0 = we_cnt;
      start_fill(32'h0000_1034, 32'h0000_1020);
      for (int i = 0; i < 20; i++) begin
         if (we_cnt - w0 >= 4) break;
         tick();
      end
      chk("rst_at_word4", 32'(we_cnt - w0), 32'd4);
      chk("rst_pre_we", 32'(cache_we), 32'd1);
      t0 = tag_cnt;
      #2;
      RST_N = 1'b0;
      #1;
      check_all_zero("async_rst");
      sb.delete();
      prev_stall = 1'b0;
      tick();
      tick();
      chk("rst_no_tag", 32'(tag_cnt - t0), 32'd0);
      RST_N = 1'b1;
      start_fill(32'h0000_3008, 32'h0000_3000);
      wait_done("restart_done", 20);
      tick();
      chk("restart_sb_drained", 32'(sb.size()), 32'd0);

`ifdef CACHE_FILL_TIMEOUT_EN
      // Stuck memory: abort pulse one cycle after the 64th stalled FETCH cycle
      mode = 2;
      t0 = tag_cnt;
      d0 = done_cnt;
      e0 = err_cnt;
      err_at = -1;
      start_fill(32'h0000_5010, 32'h0000_5000);
      sb.delete();
      for (int c = 1; c <= 70; c++) begin
         tick();
         if (last_err && err_at < 0) err_at = c;
      end
      chk("to_err_cycle", 32'(err_at), 32'd65);
      chk("to_err_pulses", 32'(err_cnt - e0), 32'd1);
      chk("to_no_done", 32'(done_cnt - d0), 32'd0);
      chk("to_no_tag", 32'(tag_cnt - t0), 32'd0);
      chk("to_idle", 32'(last_busy), 32'd0);
`else
      // Without the timeout option a stuck memory holds the fill indefinitely
      mode = 2;
      e0 = err_cnt;
      start_fill(32'h0000_5010, 32'h0000_5000);
      sb.delete();
      for (int c = 1; c <= 100; c++) begin
         tick();
      end
      chk("noto_no_err", 32'(err_cnt - e0), 32'd0);
      chk("noto_still_busy", 32'(last_busy), 32'd1);
      RST_N = 1'b0;
      tick();
      RST_N = 1'b1;
      chk("noto_recovered", 32'(fill_busy), 32'd0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
